// File: rtl/digit_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// digit_serial_add_ctrl
//
// Adds two OP_W-bit operands one DIGIT_W-bit digit per clock, LSB digit first,
// by sequencing an external combinational adder slice. The carry between
// digits is held in a register. The slice connects through the add_* ports.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready result handshake (out_sum, out_cout)
//   busy               high whenever an operation is in flight (state != IDLE)
//   add_a, add_b       current digit of the latched operands, to the slice
//   add_cin            registered inter-digit carry, to the slice
//   add_s, add_cout    slice result, combinational in the same cycle
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE and out_valid only in
// DONE, so neither ready depends combinationally on the matching valid, and
// the result stays stable in DONE until it is taken.
//
// The FSM state register is named `state` so checkers can bind to it.
// -----------------------------------------------------------------------------
module digit_serial_add_ctrl #(
    parameter  int DIGIT_W    = 2,
    parameter  int NUM_DIGITS = 8,
    localparam int OP_W       = DIGIT_W * NUM_DIGITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_a,
    input  logic [OP_W-1:0]    in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_sum,
    output logic               out_cout,
    output logic               busy,
    output logic [DIGIT_W-1:0] add_a,
    output logic [DIGIT_W-1:0] add_b,
    output logic               add_cin,
    input  logic [DIGIT_W-1:0] add_s,
    input  logic               add_cout
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic              carry;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        carry    <= in_cin;
                        idx      <= '0;
                        out_sum  <= '0;
                        out_cout <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_sum[idx*DIGIT_W +: DIGIT_W] <= add_s;
                    carry <= add_cout;
                    // idx stops at the last digit; it is re-zeroed on the
                    // next accept, so it never wraps.
                    if (idx == LAST_IDX) begin
                        out_cout <= add_cout;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register, so they change
    // only on a clock edge (or asynchronously with reset).
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // The adder slice sees zeros outside RUN so it is quiet between operations.
    assign add_a   = (state == RUN) ? a_q[idx*DIGIT_W +: DIGIT_W] : '0;
    assign add_b   = (state == RUN) ? b_q[idx*DIGIT_W +: DIGIT_W] : '0;
    assign add_cin = (state == RUN) ? carry : 1'b0;

endmodule
